// File: rtl/esdi_drive_cmd_responder.sv
// ESDI drive-side serial command responder: receives 17-bit odd-parity command frames and returns 17-bit status/config responses.
// Latency: ACK asserts ACK_DELAY cycles after the synchronised REQ is seen. cmd_valid follows the 17th bit by 2 cycles.
// Backpressure: cmd_valid/cmd_data hold until cmd_ready. The serial link stalls the host by withholding ACK. Optional ESDI_PARITY_INJECT_EN.
module esdi_drive_cmd_responder #(
    parameter int ACK_DELAY   = 6,
    parameter int BIT_TIMEOUT = 1_000_000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic        esdi_command_complete,
    output logic        esdi_attention,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_data,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [15:0] resp_data
`ifdef ESDI_PARITY_INJECT_EN
    ,
    input  logic        inject_parity_err
`endif
);

    localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam int TW = $clog2(BIT_TIMEOUT + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(ACK_DELAY - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, W_DELAY, W_HOLD, CHECK, CMD_OUT, RESP_WAIT, R_WAIT, R_DELAY, R_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        req_meta_q, req_sync_q, cd_meta_q, cd_sync_q;
    logic [DW-1:0] dly_q, dly_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [16:0] isr_q, isr_d;
    logic [16:0] osr_q, osr_d;
    logic        ack_q, ack_d, conf_q, conf_d, cc_q, cc_d, attn_q, attn_d;
    logic        req_low, armed, inj;

`ifdef ESDI_PARITY_INJECT_EN
    assign inj = inject_parity_err;
`else
    assign inj = 1'b0;
`endif

    // Lines are active low; req_low is the synchronised "host is requesting" flag.
    assign req_low = ~req_sync_q;

    // Timeout only runs while a serial frame is in flight.
    assign armed = (state_q == W_DELAY) || (state_q == W_HOLD) || (state_q == CHECK) ||
                   (state_q == R_WAIT)  || (state_q == R_DELAY) || (state_q == R_HOLD);

    assign esdi_transfer_ack     = ack_q;
    assign esdi_confstat_data    = conf_q;
    assign esdi_command_complete = cc_q;
    assign esdi_attention        = attn_q;
    assign cmd_valid             = (state_q == CMD_OUT);
    assign cmd_data              = isr_q[16:1];
    assign resp_ready            = (state_q == RESP_WAIT);

    // State register, synchronisers and all datapath/output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            req_meta_q <= 1'b1;
            req_sync_q <= 1'b1;
            cd_meta_q  <= 1'b1;
            cd_sync_q  <= 1'b1;
            dly_q      <= '0;
            tmo_q      <= '0;
            bcnt_q     <= '0;
            isr_q      <= '0;
            osr_q      <= '0;
            ack_q      <= 1'b1;
            conf_q     <= 1'b1;
            cc_q       <= 1'b0;
            attn_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_meta_q <= esdi_transfer_req;
            req_sync_q <= req_meta_q;
            cd_meta_q  <= esdi_command_data;
            cd_sync_q  <= cd_meta_q;
            dly_q      <= dly_d;
            tmo_q      <= tmo_d;
            bcnt_q     <= bcnt_d;
            isr_q      <= isr_d;
            osr_q      <= osr_d;
            ack_q      <= ack_d;
            conf_q     <= conf_d;
            cc_q       <= cc_d;
            attn_q     <= attn_d;
        end
    end

    // Next-state and output logic for the receive/respond handshake.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        tmo_d   = '0;
        bcnt_d  = bcnt_q;
        isr_d   = isr_q;
        osr_d   = osr_q;
        ack_d   = ack_q;
        conf_d  = conf_q;
        cc_d    = cc_q;
        attn_d  = attn_q;

        if (armed && (tmo_q == TMO_LAST)) begin
            // Host went silent mid-frame: release the link and flag attention.
            ack_d   = 1'b1;
            conf_d  = 1'b1;
            attn_d  = 1'b0;
            cc_d    = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_low) begin
                        cc_d    = 1'b1;
                        attn_d  = 1'b1;
                        bcnt_d  = '0;
                        dly_d   = '0;
                        state_d = W_DELAY;
                    end
                end
                W_DELAY: begin
                    if (dly_q == DLY_LAST) begin
                        isr_d   = {isr_q[15:0], ~cd_sync_q};
                        ack_d   = 1'b0;
                        state_d = W_HOLD;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                W_HOLD: begin
                    // ACK low: wait for REQ release. ACK high: waiting for next bit's REQ.
                    if (!ack_q) begin
                        if (!req_low) begin
                            ack_d  = 1'b1;
                            bcnt_d = bcnt_q + 1'b1;
                            if (bcnt_q == 5'd16) begin
                                state_d = CHECK;
                            end
                        end
                    end else if (req_low) begin
                        dly_d   = '0;
                        state_d = W_DELAY;
                    end
                end
                CHECK: begin
                    if (^isr_q) begin
                        state_d = CMD_OUT;
                    end else begin
                        attn_d  = 1'b0;
                        cc_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
                CMD_OUT: begin
                    if (cmd_ready) begin
                        if ((isr_q[16:13] == 4'd2) || (isr_q[16:13] == 4'd3)) begin
                            state_d = RESP_WAIT;
                        end else begin
                            cc_d    = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                RESP_WAIT: begin
                    if (resp_valid) begin
                        osr_d   = {resp_data, (~^resp_data) ^ inj};
                        bcnt_d  = '0;
                        state_d = R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (req_low) begin
                        conf_d  = ~osr_q[16];
                        dly_d   = '0;
                        state_d = R_DELAY;
                    end
                end
                R_DELAY: begin
                    if (dly_q == DLY_LAST) begin
                        ack_d   = 1'b0;
                        state_d = R_HOLD;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                R_HOLD: begin
                    if (!req_low) begin
                        ack_d  = 1'b1;
                        osr_d  = {osr_q[15:0], 1'b0};
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == 5'd16) begin
                            conf_d  = 1'b1;
                            cc_d    = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = R_WAIT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Timeout restarts on every state change or ACK edge.
        if (armed && (state_d == state_q) && (ack_d == ack_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_esdi_drive_cmd_responder.sv
// Bench for esdi_drive_cmd_responder: host-side serial driver plus a frame-level model of expected commands/responses.
// Latency: checks ACK latency window, command delivery and the 17-bit response contents.
// Backpressure: holds cmd_ready low to stall, all waits on the DUT are cycle-bounded.
module tb_esdi_drive_cmd_responder;

    localparam int ACK_DELAY   = 3;
    localparam int BIT_TIMEOUT = 300;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_n, cd_n;
    logic        esdi_transfer_ack, esdi_confstat_data, esdi_command_complete, esdi_attention;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_data;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
`ifdef ESDI_PARITY_INJECT_EN
    logic        inject_parity_err;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: the command the DUT is allowed to present, if any.
    logic        exp_cmd_ok = 1'b0;
    logic [15:0] exp_cmd    = '0;

    esdi_drive_cmd_responder #(.ACK_DELAY(ACK_DELAY), .BIT_TIMEOUT(BIT_TIMEOUT)) dut (
        .aclk                  (aclk),
        .areset                (areset),
        .esdi_transfer_req     (req_n),
        .esdi_command_data     (cd_n),
        .esdi_transfer_ack     (esdi_transfer_ack),
        .esdi_confstat_data    (esdi_confstat_data),
        .esdi_command_complete (esdi_command_complete),
        .esdi_attention        (esdi_attention),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_data              (cmd_data),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_data             (resp_data)
`ifdef ESDI_PARITY_INJECT_EN
        ,
        .inject_parity_err     (inject_parity_err)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Every cycle: any presented command must be one the model expects, with the expected word.
    always @(negedge aclk) begin
        if (cmd_valid === 1'b1) begin
            total++;
            if (!exp_cmd_ok || cmd_data !== exp_cmd) begin
                bad++;
                $display("FAIL cmd_stream: got valid data %0h want ok=%0b data %0h", cmd_data, exp_cmd_ok, exp_cmd);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic lvl, output int cycles);
        cycles = 0;
        while (esdi_transfer_ack !== lvl && cycles < 200) begin
            step(1);
            cycles++;
        end
        if (cycles >= 200) chk("ack_timeout", {31'd0, esdi_transfer_ack}, {31'd0, lvl});
    endtask

    // Host writes the top nbits of a 17-bit frame, MSB first, line low = 1.
    task automatic send_bits(input logic [16:0] f, input int nbits);
        int c;
        for (int i = 16; i > 16 - nbits; i--) begin
            cd_n = ~f[i];
            step(1);
            req_n = 1'b0;
            wait_ack(1'b0, c);
            req_n = 1'b1;
            wait_ack(1'b1, c);
        end
        cd_n = 1'b1;
    endtask

    task automatic send_frame(input logic [16:0] f);
        exp_cmd    = f[16:1];
        exp_cmd_ok = ($countones(f) % 2) == 1;
        send_bits(f, 17);
    endtask

    task automatic accept_cmd(input logic [15:0] want, input string nm);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, cmd_valid}, 32'd1);
        chk({nm, "_data"}, {16'd0, cmd_data}, {16'd0, want});
        cmd_ready = 1'b1;
        step(1);
        cmd_ready  = 1'b0;
        exp_cmd_ok = 1'b0;
        chk({nm, "_drop"}, {31'd0, cmd_valid}, 32'd0);
    endtask

    task automatic give_resp(input logic [15:0] d);
        int n = 0;
        while (resp_ready !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        chk("resp_ready", {31'd0, resp_ready}, 32'd1);
        resp_data  = d;
        resp_valid = 1'b1;
        step(1);
        resp_valid = 1'b0;
    endtask

    task automatic read_frame(output logic [16:0] r);
        int c;
        for (int i = 16; i >= 0; i--) begin
            req_n = 1'b0;
            wait_ack(1'b0, c);
            r[i] = ~esdi_confstat_data;
            req_n = 1'b1;
            wait_ack(1'b1, c);
        end
    endtask

    function automatic logic [16:0] model_resp(input logic [15:0] d, input logic flip);
        logic p;
        p = ($countones(d) % 2) == 0;
        return {d, p ^ flip};
    endfunction

    initial begin
        logic [16:0] r;
        int          c;
        logic        ack_seen_low;
        areset     = 1'b1;
        req_n      = 1'b1;
        cd_n       = 1'b1;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
`ifdef ESDI_PARITY_INJECT_EN
        inject_parity_err = 1'b0;
`endif
        step(3);
        chk("rst_ack",  {31'd0, esdi_transfer_ack},     32'd1);
        chk("rst_conf", {31'd0, esdi_confstat_data},    32'd1);
        chk("rst_cc",   {31'd0, esdi_command_complete}, 32'd0);
        chk("rst_attn", {31'd0, esdi_attention},        32'd1);
        chk("rst_cval", {31'd0, cmd_valid},             32'd0);
        chk("rst_rrdy", {31'd0, resp_ready},            32'd0);
        areset = 1'b0;
        step(2);

        // ACK latency on the first bit of a seek 0x0000 (parity 1).
        exp_cmd    = 16'h0000;
        exp_cmd_ok = 1'b1;
        cd_n = 1'b1;
        step(1);
        req_n = 1'b0;
        wait_ack(1'b0, c);
        total++;
        if (c < 2 + ACK_DELAY || c > 3 + ACK_DELAY) begin
            bad++;
            $display("FAIL ack_latency: got %0d want %0d..%0d", c, 2 + ACK_DELAY, 3 + ACK_DELAY);
        end
        chk("cc_busy", {31'd0, esdi_command_complete}, 32'd1);
        req_n = 1'b1;
        wait_ack(1'b1, c);
        send_bits({16'h0000, 1'b1} << 1, 16);
        accept_cmd(16'h0000, "seek");
        chk("seek_cc", {31'd0, esdi_command_complete}, 32'd0);
        chk("seek_rrdy", {31'd0, resp_ready}, 32'd0);
        chk("seek_conf", {31'd0, esdi_confstat_data}, 32'd1);
        step(5);

        // Request status 0x2000 -> response 0x1234.
        send_frame({16'h2000, 1'b0});
        accept_cmd(16'h2000, "stat");
        give_resp(16'h1234);
        read_frame(r);
        chk("stat_model", {15'd0, r}, {15'd0, model_resp(16'h1234, 1'b0)});
        chk("stat_lit",   {15'd0, r}, 32'h02468);
        chk("stat_cc",    {31'd0, esdi_command_complete}, 32'd1 - 32'd1);
        chk("stat_conf",  {31'd0, esdi_confstat_data}, 32'd1);
        step(5);

        // Bad parity frame is dropped with attention.
        send_frame({16'h0000, 1'b0});
        step(10);
        chk("bad_attn", {31'd0, esdi_attention}, 32'd0);
        chk("bad_cc",   {31'd0, esdi_command_complete}, 32'd0);
        send_frame({16'h1000, 1'b0});
        chk("rec_attn", {31'd0, esdi_attention}, 32'd1);
        accept_cmd(16'h1000, "rec");
        step(5);

        // Host abandons a frame after 5 bits.
        exp_cmd_ok = 1'b0;
        send_bits({16'hFFFF, 1'b1}, 5);
        step(BIT_TIMEOUT / 3);
        chk("tmo_early", {31'd0, esdi_attention}, 32'd1);
        step(BIT_TIMEOUT);
        chk("tmo_ack",  {31'd0, esdi_transfer_ack}, 32'd1);
        chk("tmo_attn", {31'd0, esdi_attention}, 32'd0);
        chk("tmo_cc",   {31'd0, esdi_command_complete}, 32'd0);
        send_frame({16'h4005, 1'b0});
        accept_cmd(16'h4005, "post_tmo");
        step(5);

        // Drive model stalls for 50 cycles.
        send_frame({16'h5A5A, 1'b1});
        c = 0;
        while (cmd_valid !== 1'b1 && c < 100) begin
            step(1);
            c++;
        end
        ack_seen_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (esdi_transfer_ack !== 1'b1) ack_seen_low = 1'b1;
        end
        chk("stall_vld", {31'd0, cmd_valid}, 32'd1);
        chk("stall_ack", {31'd0, ack_seen_low}, 32'd0);
        accept_cmd(16'h5A5A, "stall");
        step(5);

`ifdef ESDI_PARITY_INJECT_EN
        // Request configuration with corrupted response parity.
        send_frame({16'h3000, 1'b1});
        accept_cmd(16'h3000, "cfg");
        inject_parity_err = 1'b1;
        give_resp(16'h00FF);
        inject_parity_err = 1'b0;
        read_frame(r);
        chk("inj_model", {15'd0, r}, {15'd0, model_resp(16'h00FF, 1'b1)});
        chk("inj_lit",   {15'd0, r}, 32'h001FE);
        chk("inj_even",  ($countones(r) % 2), 32'd0);
        step(5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
